// File: rtl/matrix_loader_flat_pkg.sv
// Shared definitions for the matrix loader: default geometry, FSM state encoding
// and the flat-bus element offset helper.
package matrix_pkg;

    localparam int MAX_SIZE_DEF   = 10;
    localparam int DATA_WIDTH_DEF = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD_A = 2'd1,
        LOAD_B = 2'd2,
        FINISH = 2'd3
    } state_t;

    // Bit offset of element (r,c) inside a flattened MAX_SIZE x MAX_SIZE bus.
    function automatic int idx(input int r, input int c,
                               input int max_size   = MAX_SIZE_DEF,
                               input int data_width = DATA_WIDTH_DEF);
        return (r * max_size + c) * data_width;
    endfunction

endpackage

// File: rtl/matrix_loader_flat_if.sv
// Element stream between a serial source (master) and the matrix loader (slave).
interface matrix_loader_flat_if #(
    parameter int DATA_WIDTH = matrix_pkg::DATA_WIDTH_DEF
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/matrix_index_counter.sv
// Row/column position tracker for an N x N stream, with wrap, last-element flag
// and a selectable column-major walk order.
module matrix_index_counter #(
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             step,
    input  logic             col_major,
    input  logic [CNT_W-1:0] n,
    output logic [CNT_W-1:0] row,
    output logic [CNT_W-1:0] col,
    output logic             last
);

    logic [CNT_W-1:0] n_m1;
    logic             row_end;
    logic             col_end;

    assign n_m1    = n - CNT_W'(1);
    assign row_end = (row == n_m1);
    assign col_end = (col == n_m1);
    assign last    = row_end && col_end;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            row <= '0;
            col <= '0;
        end else if (step) begin
            if (col_major) begin
                if (row_end) begin
                    row <= '0;
                    col <= col + CNT_W'(1);
                end else begin
                    row <= row + CNT_W'(1);
                end
            end else begin
                if (col_end) begin
                    col <= '0;
                    row <= row + CNT_W'(1);
                end else begin
                    col <= col + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/matrix_loader_flat.sv
// Serial-to-parallel loader feeding matrix_mult_parallel_flat: fills A then B from
// one element stream. Define LOADER_B_COLMAJOR_EN to take the B stream column-major.
module matrix_loader_flat
    import matrix_pkg::*;
#(
    parameter int MAX_SIZE   = MAX_SIZE_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     start,
    input  logic [31:0]                              matrix_size,
    matrix_loader_flat_if.slave                      stream,
    output logic [31:0]                              size_out,
    output logic [MAX_SIZE*MAX_SIZE*DATA_WIDTH-1:0]  A,
    output logic [MAX_SIZE*MAX_SIZE*DATA_WIDTH-1:0]  B,
    output logic                                     busy,
    output logic                                     done,
    output logic                                     err
);

    localparam int CNT_W = $clog2(MAX_SIZE) + 1;

    state_t           state;
    state_t           state_nxt;
    logic             size_ok;
    logic             start_ok;
    logic             accept;
    logic             last;
    logic             cnt_clear;
    logic             col_major;
    logic [CNT_W-1:0] row;
    logic [CNT_W-1:0] col;

    assign size_ok  = (matrix_size != 32'd0) && (matrix_size <= 32'(MAX_SIZE));
    assign start_ok = (state == IDLE) && start && size_ok;
    assign accept   = stream.in_valid && stream.in_ready;
    // Re-arm the shared counter at the start of A and again at the A->B handover.
    assign cnt_clear = start_ok || ((state == LOAD_A) && accept && last);

`ifdef LOADER_B_COLMAJOR_EN
    assign col_major = (state == LOAD_B);
`else
    assign col_major = 1'b0;
`endif

    matrix_index_counter #(.CNT_W(CNT_W)) u_index (
        .clk       (clk),
        .rst       (rst),
        .clear     (cnt_clear),
        .step      (accept),
        .col_major (col_major),
        .n         (size_out[CNT_W-1:0]),
        .row       (row),
        .col       (col),
        .last      (last)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // NOTE: every signal driven here gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start_ok)        state_nxt = LOAD_A;
            LOAD_A:  if (accept && last)  state_nxt = LOAD_B;
            LOAD_B:  if (accept && last)  state_nxt = FINISH;
            FINISH:                       state_nxt = IDLE;
            default:                      state_nxt = IDLE;
        endcase
    end

    // Moore outputs decoded straight from the state register.
    always_comb begin
        stream.in_ready = 1'b0;
        busy            = 1'b0;
        done            = 1'b0;
        unique case (state)
            LOAD_A, LOAD_B: begin
                stream.in_ready = 1'b1;
                busy            = 1'b1;
            end
            FINISH:  done = 1'b1;
            default: ;
        endcase
    end

    // NOTE: the operand buses are plain flops, not a RAM, so they are reset here;
    // a memory macro would have to be cleared by a sequencer instead.
    always_ff @(posedge clk) begin
        if (rst) begin
            size_out <= '0;
            A        <= '0;
            B        <= '0;
            err      <= 1'b0;
        end else begin
            err <= 1'b0;
            if ((state == IDLE) && start) begin
                if (size_ok) begin
                    size_out <= matrix_size;
                    A        <= '0;
                    B        <= '0;
                end else begin
                    err <= 1'b1;
                end
            end
            if (accept) begin
                if (state == LOAD_A)
                    A[idx(int'(row), int'(col), MAX_SIZE, DATA_WIDTH) +: DATA_WIDTH] <= stream.in_data;
                else
                    B[idx(int'(row), int'(col), MAX_SIZE, DATA_WIDTH) +: DATA_WIDTH] <= stream.in_data;
            end
        end
    end

endmodule

// File: tb/tb_matrix_loader_flat.sv
// Directed bench for matrix_loader_flat: loads, timing, backpressure, illegal sizes,
// mid-load reset. Tracks LOADER_B_COLMAJOR_EN for the B layout model.
module tb_matrix_loader_flat;

    localparam int MAXS = 10;
    localparam int DW   = 32;
    localparam int BW   = MAXS * MAXS * DW;

    logic          clk;
    logic          rst;
    logic          start;
    logic [31:0]   matrix_size;
    logic [31:0]   size_out;
    logic [BW-1:0] A;
    logic [BW-1:0] B;
    logic          busy;
    logic          done;
    logic          err;

    matrix_loader_flat_if #(.DATA_WIDTH(DW)) bus ();

    matrix_loader_flat #(.MAX_SIZE(MAXS), .DATA_WIDTH(DW)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .matrix_size (matrix_size),
        .stream      (bus.slave),
        .size_out    (size_out),
        .A           (A),
        .B           (B),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int sa[MAXS*MAXS];
    int sb[MAXS*MAXS];

`ifdef LOADER_B_COLMAJOR_EN
    localparam bit B_CM = 1'b1;
`else
    localparam bit B_CM = 1'b0;
`endif

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] el(input logic [BW-1:0] m, input int r, input int c);
        return m[(r*MAXS+c)*DW +: DW];
    endfunction

    // Expected bus from the stream arrays; B may be column-major.
    function automatic logic [BW-1:0] build_exp(input int n, input bit is_b);
        logic [BW-1:0] m;
        int r, c;
        m = '0;
        for (int k = 0; k < n*n; k++) begin
            if (is_b && B_CM) begin r = k % n; c = k / n; end
            else              begin r = k / n; c = k % n; end
            m[(r*MAXS+c)*DW +: DW] = is_b ? DW'(sb[k]) : DW'(sa[k]);
        end
        return m;
    endfunction

    function automatic longint c_dut(input int r, input int c, input int n);
        longint s = 0;
        for (int k = 0; k < n; k++) s += longint'(el(A, r, k)) * longint'(el(B, k, c));
        return s;
    endfunction

    function automatic longint c_model(input int r, input int c, input int n);
        longint s = 0;
        for (int k = 0; k < n; k++)
            s += longint'(sa[r*n+k]) * longint'(B_CM ? sb[c*n+k] : sb[k*n+c]);
        return s;
    endfunction

    task automatic check_mat(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
        for (int i = 0; i < MAXS*MAXS; i++)
            check($sformatf("%s[%0d]", tag, i), 64'(got[i*DW +: DW]), 64'(exp[i*DW +: DW]));
    endtask

    // Issues start, streams sa then sb whenever in_ready is high, returns the
    // cycle (counted from start) on which done was seen.
    task automatic do_load(input int n, input bit gaps, output int done_cyc);
        int k = 0;
        int beat = 0;
        int cyc = 0;
        bit pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        bit v;
        done_cyc = -1;
        @(negedge clk);
        start = 1'b1;
        matrix_size = 32'(n);
        bus.in_valid = 1'b0;
        while (cyc < 1000 && done_cyc < 0) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (cyc == 1) check("load_busy_c1", 64'(busy), 64'd1);
            if (done) begin
                done_cyc = cyc;
                bus.in_valid = 1'b0;
                check("finish_in_ready", 64'(bus.in_ready), 64'd0);
            end else if (bus.in_ready && k < 2*n*n) begin
                v = gaps ? pat[beat % 4] : 1'b1;
                beat++;
                bus.in_valid = v;
                bus.in_data  = (k < n*n) ? DW'(sa[k]) : DW'(sb[k-n*n]);
                if (v) k++;
            end else begin
                bus.in_valid = 1'b0;
            end
        end
        @(negedge clk);
        check("done_one_cycle", 64'(done), 64'd0);
        check("idle_busy", 64'(busy), 64'd0);
    endtask

    logic [BW-1:0] keep_a;
    logic [BW-1:0] keep_b;
    int dc;

    initial begin
        rst = 1'b1;
        start = 1'b0;
        matrix_size = '0;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'd0);
        check("rst_size_out", 64'(size_out), 64'd0);
        check("rst_A_zero", 64'(A == '0), 64'd1);
        check("rst_B_zero", 64'(B == '0), 64'd1);
        rst = 1'b0;

        // Size 2, uninterrupted stream.
        for (int i = 0; i < 4; i++) begin sa[i] = i + 1; sb[i] = i + 5; end
        do_load(2, 1'b0, dc);
        check("n2_done_cycle", 64'(dc), 64'd9);
        check("n2_size_out", 64'(size_out), 64'd2);
        check("n2_A_w0", 64'(el(A, 0, 0)), 64'd1);
        check("n2_A_w1", 64'(el(A, 0, 1)), 64'd2);
        check("n2_A_w10", 64'(el(A, 1, 0)), 64'd3);
        check("n2_A_w11", 64'(el(A, 1, 1)), 64'd4);
`ifdef LOADER_B_COLMAJOR_EN
        check("cm_B00", 64'(el(B, 0, 0)), 64'd5);
        check("cm_B10", 64'(el(B, 1, 0)), 64'd6);
        check("cm_B01", 64'(el(B, 0, 1)), 64'd7);
        check("cm_B11", 64'(el(B, 1, 1)), 64'd8);
        check("n2_C00", 64'(c_dut(0, 0, 2)), 64'd17);
        check("n2_C01", 64'(c_dut(0, 1, 2)), 64'd23);
        check("n2_C10", 64'(c_dut(1, 0, 2)), 64'd39);
        check("n2_C11", 64'(c_dut(1, 1, 2)), 64'd53);
`else
        check("n2_C00", 64'(c_dut(0, 0, 2)), 64'd19);
        check("n2_C01", 64'(c_dut(0, 1, 2)), 64'd22);
        check("n2_C10", 64'(c_dut(1, 0, 2)), 64'd43);
        check("n2_C11", 64'(c_dut(1, 1, 2)), 64'd50);
`endif
        check_mat("n2_A", A, build_exp(2, 1'b0));
        check_mat("n2_B", B, build_exp(2, 1'b1));

        // Illegal sizes: err pulses, contents and size_out untouched.
        keep_a = A;
        keep_b = B;
        for (int t = 0; t < 2; t++) begin
            @(negedge clk);
            start = 1'b1;
            matrix_size = (t == 0) ? 32'd0 : 32'd11;
            @(negedge clk);
            start = 1'b0;
            check($sformatf("bad%0d_err", t), 64'(err), 64'd1);
            check($sformatf("bad%0d_busy", t), 64'(busy), 64'd0);
            @(negedge clk);
            check($sformatf("bad%0d_err_drop", t), 64'(err), 64'd0);
            check($sformatf("bad%0d_busy2", t), 64'(busy), 64'd0);
        end
        check("bad_A_kept", 64'(A == keep_a), 64'd1);
        check("bad_B_kept", 64'(B == keep_b), 64'd1);
        check("bad_size_kept", 64'(size_out), 64'd2);

        // Size 3 with 1,0,0,1 valid pattern: 18 idle beats interleaved.
        for (int i = 0; i < 9; i++) begin sa[i] = 10 + i; sb[i] = 20 + i; end
        do_load(3, 1'b1, dc);
        check("bp_done_cycle", 64'(dc), 64'd37);
        check_mat("bp_A", A, build_exp(3, 1'b0));
        check_mat("bp_B", B, build_exp(3, 1'b1));

        // Full size 10.
        for (int i = 0; i < 100; i++) begin sa[i] = i + 1; sb[i] = 101 + i; end
        do_load(10, 1'b0, dc);
        check("n10_done_cycle", 64'(dc), 64'd201);
        check_mat("n10_A", A, build_exp(10, 1'b0));
        check_mat("n10_B", B, build_exp(10, 1'b1));
        check("n10_C00", 64'(c_dut(0, 0, 10)), 64'(c_model(0, 0, 10)));
        check("n10_C99", 64'(c_dut(9, 9, 10)), 64'(c_model(9, 9, 10)));
        check("n10_C37", 64'(c_dut(3, 7, 10)), 64'(c_model(3, 7, 10)));

        // Reset after the 5th A element of a size-4 load.
        @(negedge clk);
        start = 1'b1;
        matrix_size = 32'd4;
        @(negedge clk);
        start = 1'b0;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.in_data = DW'(50 + i);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        check("mid_A10", 64'(el(A, 1, 0)), 64'd54);
        check("mid_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mrst_A_zero", 64'(A == '0), 64'd1);
        check("mrst_B_zero", 64'(B == '0), 64'd1);
        check("mrst_in_ready", 64'(bus.in_ready), 64'd0);
        check("mrst_busy", 64'(busy), 64'd0);
        check("mrst_size_out", 64'(size_out), 64'd0);

        for (int i = 0; i < 4; i++) begin sa[i] = 9 - i; sb[i] = 3 * i + 1; end
        do_load(2, 1'b0, dc);
        check("post_done_cycle", 64'(dc), 64'd9);
        check_mat("post_A", A, build_exp(2, 1'b0));
        check_mat("post_B", B, build_exp(2, 1'b1));
        check("post_C00", 64'(c_dut(0, 0, 2)), 64'(c_model(0, 0, 2)));
        check("post_C11", 64'(c_dut(1, 1, 2)), 64'(c_model(1, 1, 2)));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/matrix_loader_flat.md
Name: matrix_loader_flat

Overview:
- Upstream stage of matrix_mult_parallel_flat.
- Accepts matrix elements one per cycle over a valid/ready stream and assembles the flattened A and B operand buses at the multiplier's MAX_SIZE pitch.
- Signals completion so the downstream combinational multiplier output C can be sampled.
- Decouples narrow serial sources (UART, DMA, host bus) from the wide parallel multiplier inputs.

Parameters:
- MAX_SIZE, 10, maximum matrix dimension; must match the multiplier.
- DATA_WIDTH, 32, element width in bits.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  begin a load; sampled only in IDLE
- matrix_size  input  32  dimension N, sampled on accepted start
- in_valid  input  1  in_data is valid
- in_ready  output  1  loader accepts in_data this cycle
- in_data  input  DATA_WIDTH  element value
- size_out  output  32  latched N; drives the multiplier's matrix_size
- A  output  MAX_SIZE*MAX_SIZE*DATA_WIDTH  flattened A; element (r,c) at bits ((r*MAX_SIZE+c)*DATA_WIDTH) +: DATA_WIDTH
- B  output  MAX_SIZE*MAX_SIZE*DATA_WIDTH  flattened B, same layout as A
- busy  output  1  high in LOAD_A and LOAD_B
- done  output  1  one-cycle pulse when both matrices are complete
- err  output  1  one-cycle pulse when start is rejected

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- Reset values:
  - State IDLE.
  - A=0, B=0, size_out=0.
  - in_ready=0, busy=0, done=0, err=0.
  - Row/col counters 0.
- FSM states: IDLE, LOAD_A, LOAD_B, FINISH.
- IDLE:
  - start=1 with 1<=matrix_size<=MAX_SIZE: latch size_out=matrix_size, clear A and B to all-zero, reset row=col=0, go to LOAD_A.
  - start=1 with matrix_size=0 or >MAX_SIZE: err=1 for one cycle, stay in IDLE, leave A/B/size_out unchanged.
- LOAD_A / LOAD_B:
  - in_ready=1 (registered, high every cycle in these states).
  - An element is accepted when in_valid&&in_ready.
  - Stream order is row-major: col increments first; on col=N-1, col wraps to 0 and row increments.
  - An accepted element is written into the target matrix at (row,col) in the same edge.
  - When element (N-1,N-1) of A is accepted, reset counters and go to LOAD_B.
  - When element (N-1,N-1) of B is accepted, go to FINISH.
  - in_valid low stalls the load indefinitely; counters hold.
- FINISH: done=1 for exactly one cycle, then IDLE. in_ready=0.
- Latency: done is asserted on the cycle after the final B element is accepted. Total load time is minimum 2*N*N+1 cycles after start.
- Output stability:
  - A, B and size_out hold their values in IDLE until the next accepted start.
  - The downstream C is valid from the done cycle onward.
- Unused elements (row or col >= N) read 0.
- start while busy or in FINISH is ignored; it is not queued.
- rst mid-load: outputs return to reset values on the next edge. The partial load is discarded.
- Arithmetic: counters are $clog2(MAX_SIZE) bits wide plus margin. No overflow is possible because N<=MAX_SIZE.

Optional Feature:
- Macro: LOADER_B_COLMAJOR_EN.
- Defined: the B stream is column-major. Row increments first; the element is written at (row,col) after the index swap, so in_data k lands at B(k%N, k/N). A is unaffected.
- Undefined: B is row-major, identical to A.

Decomposition:
- Shared package matrix_pkg:
  - MAX_SIZE and DATA_WIDTH defaults.
  - State enum (IDLE, LOAD_A, LOAD_B, FINISH).
  - Flat-index function idx(r,c) = (r*MAX_SIZE+c)*DATA_WIDTH.
- One natural sub-module: matrix_index_counter. It holds the row/col counters with wrap, a last-element flag and the optional column-major order. It is instantiated once and re-armed for B.

Test Plan:
- Size 2, A stream 1,2,3,4, B stream 5,6,7,8, in_valid always high:
  - A words [0]=1, [1]=2, [10]=3, [11]=4.
  - done pulses exactly at cycle 9 after start.
  - Multiplier C(0,0)=19, C(0,1)=22, C(1,0)=43, C(1,1)=50.
- Size 10, A=1..100, B column-major values matching the existing multiplier bench:
  - C(0,0)=38500/... matches the golden model.
  - done is one cycle after the 200th accept.
- Backpressure: size 3, in_valid toggled 1,0,0,1 pattern:
  - Only valid-high beats are accepted; counters hold while in_valid is low.
  - done is delayed by exactly the count of idle cycles.
- Illegal sizes: start with matrix_size=0, then 11:
  - err pulses once for each.
  - busy stays 0; A and B keep their prior contents.
- rst asserted after the 5th A element of a size-4 load:
  - Next cycle: A=0, B=0, state IDLE, in_ready=0.
  - A fresh size-2 load then completes correctly.
- With LOADER_B_COLMAJOR_EN, size 2, B stream 5,6,7,8:
  - B(0,0)=5, B(1,0)=6, B(0,1)=7, B(1,1)=8.
